// File: rtl/quad_encoder_gen_if.sv
// Move-command channel for the quadrature encoder generator.
// The master issues moves and aborts; the slave (the generator) reports readiness.
interface quad_encoder_gen_if #(
    parameter int STEP_W = 16,
    parameter int DIV_W  = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [STEP_W-1:0] cmd_steps;
    logic [DIV_W-1:0]  step_div;
    logic              abort;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, step_div, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, step_div, abort,
        output cmd_ready
    );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator.
// Emits a commanded number of A/B quadrature steps at a programmable rate and tracks the angular position.
module quad_encoder_gen #(
    parameter int CPR    = 400,
    parameter int STEP_W = 16,
    parameter int DIV_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    quad_encoder_gen_if.slave       cmd,
    output logic                    A,
    output logic                    B,
    output logic                    Z,
    output logic [$clog2(CPR)-1:0]  position,
    output logic                    busy,
    output logic                    done
);
    localparam int              POS_W   = $clog2(CPR);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(CPR - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [STEP_W-1:0] remaining_reg;
    logic              dir_reg;
    logic [POS_W-1:0]  position_reg;
    logic [POS_W-1:0]  position_next;
    logic              a_reg, b_reg, z_reg, done_reg;
    logic              ready;
    logic              accept;
    logic              tick;
    logic              last_step;

    assign accept    = cmd.cmd_valid && ready;
    assign tick      = (state_reg == RUN) && (div_cnt_reg == div_reg);
    assign last_step = (remaining_reg == STEP_W'(1));

    // Wrap-around step in the latched direction; only committed on a tick.
    always_comb begin
        position_next = position_reg;
        if (dir_reg) begin
            position_next = (position_reg == '0) ? POS_MAX : position_reg - POS_W'(1);
        end else begin
            position_next = (position_reg == POS_MAX) ? '0 : position_reg + POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept && (cmd.cmd_steps != '0)) state_next = RUN;
            RUN: begin
                if (cmd.abort) begin
                    state_next = IDLE;
                end else if (tick && last_step) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_reg == RUN);
        ready = (state_reg == IDLE) && !cmd.abort;
    end

    // An abort in RUN freezes position and outputs; counters are reloaded on the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg   <= '0;
            div_reg       <= '0;
            remaining_reg <= '0;
            dir_reg       <= 1'b0;
            position_reg  <= '0;
            a_reg         <= 1'b0;
            b_reg         <= 1'b0;
            z_reg         <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                dir_reg       <= cmd.cmd_dir;
                div_reg       <= cmd.step_div;
                remaining_reg <= cmd.cmd_steps;
                div_cnt_reg   <= '0;
                if (cmd.cmd_steps == '0) done_reg <= 1'b1;
            end else if ((state_reg == RUN) && !cmd.abort) begin
                if (tick) begin
                    div_cnt_reg   <= '0;
                    remaining_reg <= remaining_reg - STEP_W'(1);
                    position_reg  <= position_next;
                    a_reg         <= position_next[1] ^ position_next[0];
                    b_reg         <= position_next[1];
                    z_reg         <= (position_next == '0);
                    if (last_step) done_reg <= 1'b1;
                end else begin
                    div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                end
            end
        end
    end

    assign cmd.cmd_ready = ready;
    assign position      = position_reg;
    assign A             = a_reg;
    assign B             = b_reg;
    assign Z             = z_reg;
    assign done          = done_reg;
endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: directed scenarios plus random traffic,
// checked every cycle against a move-level reference model.
module tb_quad_encoder_gen;
    localparam int CPR    = 8;
    localparam int STEP_W = 8;
    localparam int DIV_W  = 8;

    logic clk = 1'b0;
    logic rst;
    logic A, B, Z, busy, done;
    logic [2:0] position;

    always #5 clk = ~clk;

    quad_encoder_gen_if #(.STEP_W(STEP_W), .DIV_W(DIV_W)) cmd_if ();

    quad_encoder_gen #(.CPR(CPR), .STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if),
        .A        (A),
        .B        (B),
        .Z        (Z),
        .position (position),
        .busy     (busy),
        .done     (done)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a move is described by its start, period and step count.
    int m_pos = 0, m_elapsed = 0, m_applied = 0, m_steps = 0, m_period = 1;
    bit m_dir = 0, m_busy = 0, m_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        if (rst) begin
            m_busy = 0; m_done = 0; m_pos = 0;
        end else if (m_busy) begin
            m_done = 0;
            m_elapsed++;
            if (cmd_if.abort) begin
                m_busy = 0;
            end else if (m_elapsed % m_period == 0) begin
                m_pos = m_dir ? (m_pos + CPR - 1) % CPR : (m_pos + 1) % CPR;
                m_applied++;
                if (m_applied == m_steps) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end else begin
            m_done = 0;
            if (cmd_if.cmd_valid && !cmd_if.abort) begin
                m_dir     = cmd_if.cmd_dir;
                m_steps   = int'(cmd_if.cmd_steps);
                m_period  = int'(cmd_if.step_div) + 1;
                m_elapsed = 0;
                m_applied = 0;
                if (m_steps == 0) m_done = 1;
                else              m_busy = 1;
            end
        end
    endfunction

    task automatic check_all();
        int q;
        q = m_pos % 4;
        check("position", 32'(position), 32'(m_pos));
        check("A", 32'(A), 32'((q == 1) || (q == 2)));
        check("B", 32'(B), 32'(q >= 2));
        check("Z", 32'(Z), 32'(m_pos == 0));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(!m_busy && !cmd_if.abort));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_cmd(input bit dir, input int steps, input int div);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_steps = STEP_W'(steps);
        cmd_if.step_div  = DIV_W'(div);
        cyc();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = '0;
        cmd_if.step_div  = '0;
        cmd_if.abort     = 1'b0;

        // Reset held for two cycles
        idle(2);
        rst = 1'b0;
        cyc();
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("rst_z", 32'(Z), 32'd1);

        // Clockwise 5 steps, divide by 3
        send_cmd(1'b0, 5, 2);
        idle(15);
        check("cw5_pos", 32'(position), 32'd5);
        check("cw5_done", 32'(done), 32'd1);
        idle(1);

        // Antihorario 3 steps from 0
        pulse_reset();
        send_cmd(1'b1, 3, 0);
        cyc();
        check("ccw_first", 32'(position), 32'd7);
        idle(2);
        check("ccw3_pos", 32'(position), 32'd5);
        check("ccw3_ab", 32'({A, B}), 32'b10);

        // Full revolution with an ignored command mid-move
        pulse_reset();
        send_cmd(1'b0, 8, 0);
        idle(3);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = 1'b1;
        cmd_if.cmd_steps = STEP_W'(2);
        cyc();
        cmd_if.cmd_valid = 1'b0;
        idle(4);
        check("wrap_pos", 32'(position), 32'd0);
        check("wrap_z", 32'(Z), 32'd1);
        idle(1);
        check("wrap_idle", 32'(busy), 32'd0);

        // Abort coincident with the second tick
        send_cmd(1'b0, 10, 3);
        idle(7);
        cmd_if.abort = 1'b1;
        cyc();
        cmd_if.abort = 1'b0;
        check("abort_pos", 32'(position), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        send_cmd(1'b0, 1, 0);
        check("post_abort_accept", 32'(busy), 32'd1);
        idle(2);

        // Zero-step command
        send_cmd(1'b1, 0, 5);
        check("zero_done", 32'(done), 32'd1);
        check("zero_pos", 32'(position), 32'd2);
        idle(1);

        // Reset mid-move, and a command presented under reset
        send_cmd(1'b0, 6, 0);
        idle(2);
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_steps = STEP_W'(3);
        cyc();
        rst = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        check("rst_mid_pos", 32'(position), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        idle(2);

        // Maximum step count
        send_cmd(1'b0, 255, 0);
        idle(255);
        check("max_done", 32'(done), 32'd1);
        check("max_pos", 32'(position), 32'(255 % CPR));
        idle(1);

        // Random traffic, including field changes and aborts during moves
        repeat (800) begin
            rst              = ($urandom_range(0, 199) == 0);
            cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_if.cmd_dir   = 1'($urandom_range(0, 1));
            cmd_if.cmd_steps = STEP_W'($urandom_range(0, 12));
            cmd_if.step_div  = DIV_W'($urandom_range(0, 3));
            cmd_if.abort     = ($urandom_range(0, 15) == 0);
            cyc();
        end
        rst              = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.abort     = 1'b0;
        idle(60);
        check("drain_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
